// File: rtl/seq_adder_chunked.sv
// Chunk-serial add/subtract unit: operands arrive LSB chunk first, a registered ripple
// carry links the chunks, and the completed result and flags are held until the next op finishes.
module seq_adder_chunked #(
   parameter  int CHUNK_W    = 12,
   parameter  int NUM_CHUNKS = 4,
   localparam int TOTAL_W    = CHUNK_W * NUM_CHUNKS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sub,
   input  logic [CHUNK_W-1:0] in_a,
   input  logic [CHUNK_W-1:0] in_b,
   output logic               busy,
   output logic               result_valid,
   output logic [TOTAL_W-1:0] result,
   output logic               carry_out,
   output logic               overflow
);

   localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic               carryReg;
   logic               subReg;
   logic [TOTAL_W-1:0] shiftReg;

   logic               accept;
   logic               step;
   logic               opSub;
   logic               carryIn;
   logic               lastChunk;
   logic               msbCarryIn;
   logic [CHUNK_W-1:0] bEff;
   logic [CHUNK_W:0]   sum;
   logic [TOTAL_W-1:0] sumExt;
   logic [TOTAL_W-1:0] shiftNext;

   always_comb begin
      accept     = (state != ACCUM) && start;
      step       = accept || (state == ACCUM);
      // The first chunk uses the live sub input; later chunks use the latched mode.
      opSub      = accept ? sub : subReg;
      carryIn    = accept ? sub : carryReg;
      bEff       = opSub ? ~in_b : in_b;
      sum        = {1'b0, in_a} + {1'b0, bEff} + {{CHUNK_W{1'b0}}, carryIn};
      lastChunk  = accept ? (NUM_CHUNKS == 1) : (cnt == LAST_CNT);
      msbCarryIn = in_a[CHUNK_W-1] ^ bEff[CHUNK_W-1] ^ sum[CHUNK_W-1];
      sumExt     = TOTAL_W'(sum[CHUNK_W-1:0]);
      // Shift form stays legal when NUM_CHUNKS == 1 (no empty part-select).
      shiftNext  = (shiftReg >> CHUNK_W) | (sumExt << (TOTAL_W - CHUNK_W));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         carryReg     <= 1'b0;
         subReg       <= 1'b0;
         shiftReg     <= '0;
         result_valid <= 1'b0;
         result       <= '0;
         carry_out    <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (step) begin
            carryReg <= sum[CHUNK_W];
            shiftReg <= shiftNext;
            if (accept) begin
               subReg <= sub;
               cnt    <= CNT_W'(1);
            end else begin
               cnt    <= cnt + CNT_W'(1);
            end
            if (lastChunk) begin
               state        <= DONE;
               result       <= shiftNext;
               carry_out    <= sum[CHUNK_W];
               overflow     <= msbCarryIn ^ sum[CHUNK_W];
               result_valid <= 1'b1;
            end else begin
               state <= ACCUM;
            end
         end else begin
            state <= IDLE;
         end
      end
   end

   assign busy = (state == ACCUM);

endmodule

// File: tb/tb_seq_adder_chunked.sv
// Directed bench: 12x4 instance for the main cases, plus an 8x1 instance for the
// single-chunk corner; expected values are hand-computed constants.
module tb_seq_adder_chunked;

   localparam int CW = 12;
   localparam int NC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, sub;
   logic [CW-1:0] in_a, in_b;
   logic          busy, result_valid, carry_out, overflow;
   logic [47:0]   result;

   logic          start2, sub2;
   logic [7:0]    in_a2, in_b2;
   logic          busy2, result_valid2, carry_out2, overflow2;
   logic [7:0]    result2;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   seq_adder_chunked #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .in_a(in_a), .in_b(in_b),
      .busy(busy), .result_valid(result_valid), .result(result),
      .carry_out(carry_out), .overflow(overflow)
   );

   seq_adder_chunked #(.CHUNK_W(8), .NUM_CHUNKS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start2), .sub(sub2), .in_a(in_a2), .in_b(in_b2),
      .busy(busy2), .result_valid(result_valid2), .result(result2),
      .carry_out(carry_out2), .overflow(overflow2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Called at a negedge; returns at the negedge after the final-chunk edge.
   task automatic doOp(input string tag, input logic [47:0] a, input logic [47:0] b,
                       input logic s, input logic [47:0] prevRes, input logic spur);
      start = 1'b1; sub = s; in_a = a[CW-1:0]; in_b = b[CW-1:0];
      for (int k = 1; k < NC; k++) begin
         @(negedge clk);
         chk({tag, " busy"}, 64'(busy), 64'd1);
         chk({tag, " valid early"}, 64'(result_valid), 64'd0);
         chk({tag, " result held"}, 64'(result), 64'(prevRes));
         start = spur && (k == 2);
         sub   = spur ? ~s : s;
         in_a  = a[k*CW +: CW];
         in_b  = b[k*CW +: CW];
      end
      @(negedge clk);
      start = 1'b0;
      chk({tag, " valid"}, 64'(result_valid), 64'd1);
      chk({tag, " busy done"}, 64'(busy), 64'd0);
   endtask

   task automatic chkRes(input string tag, input logic [47:0] r, input logic c, input logic o);
      chk({tag, " result"}, 64'(result), 64'(r));
      chk({tag, " carry"}, 64'(carry_out), 64'(c));
      chk({tag, " ovf"}, 64'(overflow), 64'(o));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; in_a = '0; in_b = '0;
      start2 = 1'b0; sub2 = 1'b0; in_a2 = '0; in_b2 = '0;
      repeat (2) @(negedge clk);
      chk("rst result", 64'(result), 64'd0);
      chk("rst valid", 64'(result_valid), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst carry", 64'(carry_out), 64'd0);
      chk("rst ovf", 64'(overflow), 64'd0);
      chk("rst result2", 64'(result2), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // T1
      doOp("t1", 48'h000000000001, 48'hFFFFFFFFFFFF, 1'b0, 48'h0, 1'b0);
      chkRes("t1", 48'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t1 valid pulse", 64'(result_valid), 64'd0);

      // T2
      doOp("t2", 48'h000000000000, 48'h000000000001, 1'b1, 48'h0, 1'b0);
      chkRes("t2", 48'hFFFFFFFFFFFF, 1'b0, 1'b0);
      @(negedge clk);

      // T3
      doOp("t3a", 48'h7FFFFFFFFFFF, 48'h000000000001, 1'b0, 48'hFFFFFFFFFFFF, 1'b0);
      chkRes("t3a", 48'h800000000000, 1'b0, 1'b1);
      @(negedge clk);
      doOp("t3b", 48'h800000000000, 48'h000000000001, 1'b1, 48'h800000000000, 1'b0);
      chkRes("t3b", 48'h7FFFFFFFFFFF, 1'b1, 1'b1);
      @(negedge clk);

      // T4: op2 starts in op1's DONE cycle; spurious start during op2
      doOp("t4a", 48'h123456789ABC, 48'h000000000444, 1'b0, 48'h7FFFFFFFFFFF, 1'b0);
      chkRes("t4a", 48'h123456789F00, 1'b0, 1'b0);
      doOp("t4b", 48'h100000000000, 48'h000000000001, 1'b1, 48'h123456789F00, 1'b1);
      chkRes("t4b", 48'h0FFFFFFFFFFF, 1'b1, 1'b0);
      @(negedge clk);
      chk("t4 valid pulse", 64'(result_valid), 64'd0);

      // T5: reset on the edge that would consume chunk 3
      start = 1'b1; sub = 1'b0; in_a = 12'h111; in_b = 12'h222;
      for (int k = 1; k < 3; k++) begin
         @(negedge clk);
         start = 1'b0; in_a = 12'h333; in_b = 12'h444;
      end
      @(negedge clk);
      chk("t5 busy pre", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5 busy", 64'(busy), 64'd0);
      chk("t5 valid", 64'(result_valid), 64'd0);
      chkRes("t5 rst", 48'h0, 1'b0, 1'b0);
      doOp("t5", 48'h123456789ABC, 48'h111111111111, 1'b0, 48'h0, 1'b0);
      chkRes("t5", 48'h23456789ABCD, 1'b0, 1'b0);
      @(negedge clk);

      // T6: single-chunk instance, back-to-back in DONE
      start2 = 1'b1; sub2 = 1'b0; in_a2 = 8'h7F; in_b2 = 8'h01;
      @(negedge clk);
      chk("t6 valid", 64'(result_valid2), 64'd1);
      chk("t6 busy", 64'(busy2), 64'd0);
      chk("t6 result", 64'(result2), 64'h80);
      chk("t6 ovf", 64'(overflow2), 64'd1);
      chk("t6 carry", 64'(carry_out2), 64'd0);
      sub2 = 1'b1; in_a2 = 8'h00; in_b2 = 8'h01;
      @(negedge clk);
      start2 = 1'b0;
      chk("t6b valid", 64'(result_valid2), 64'd1);
      chk("t6b busy", 64'(busy2), 64'd0);
      chk("t6b result", 64'(result2), 64'hFF);
      chk("t6b carry", 64'(carry_out2), 64'd0);
      chk("t6b ovf", 64'(overflow2), 64'd0);
      @(negedge clk);
      chk("t6 valid pulse", 64'(result_valid2), 64'd0);
      chk("t6 result held", 64'(result2), 64'hFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
